// File: rtl/exc_commit.sv
// rtl/exc_commit.sv - WB-stage exception/ertn commit controller with flush window.
// Interrupt path is compiled in only when EXC_INT_EN is defined.
module exc_commit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_vaddr,
  input  logic        ws_ex_adef,
  input  logic        ws_ex_ine,
  input  logic        ws_ex_sys,
  input  logic        ws_ex_brk,
  input  logic        ws_ex_ale,
  input  logic        ws_ertn,
  input  logic        ws_csr_we,
  input  logic        csr_crmd_ie,
  input  logic [12:0] csr_ecfg_lie,
  input  logic [12:0] csr_estat_is,
  output logic        csr_we,
  output logic        rf_we_gate,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  output logic        flush
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        int_pend;
  logic        accepted;
  logic        any_flag;
  logic        take_ex;
  logic        take_ertn;
  logic [5:0]  ecode_nxt;
  logic [31:0] vaddr_nxt;

`ifdef EXC_INT_EN
  assign int_pend = csr_crmd_ie & (|(csr_ecfg_lie & csr_estat_is));
`else
  logic int_unused;
  assign int_unused = ^{csr_crmd_ie, csr_ecfg_lie, csr_estat_is};
  assign int_pend   = 1'b0;
`endif

  // Commits seen while the front end is still redirecting are discarded.
  assign accepted   = ws_valid && (state == IDLE);
  assign any_flag   = ws_ex_adef | ws_ex_ine | ws_ex_sys | ws_ex_brk | ws_ex_ale;
  assign take_ex    = accepted && (int_pend || any_flag);
  assign take_ertn  = accepted && ws_ertn && !take_ex;
  assign csr_we     = ws_csr_we && accepted && !take_ex;
  assign rf_we_gate = accepted && !take_ex;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ecode_nxt = 6'h00;
    vaddr_nxt = 32'h0;

    // Interrupt is taken precisely before the retiring instruction, so it wins.
    if (int_pend) begin
      ecode_nxt = 6'h00;
    end else if (ws_ex_adef) begin
      ecode_nxt = 6'h08;
      vaddr_nxt = ws_pc;
    end else if (ws_ex_ine) begin
      ecode_nxt = 6'h0D;
    end else if (ws_ex_sys) begin
      ecode_nxt = 6'h0B;
    end else if (ws_ex_brk) begin
      ecode_nxt = 6'h0C;
    end else if (ws_ex_ale) begin
      ecode_nxt = 6'h09;
      vaddr_nxt = ws_vaddr;
    end

    case (state)
      IDLE: begin
        if (take_ex || take_ertn) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_INIT;
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      wb_ex       <= 1'b0;
      ertn_flush  <= 1'b0;
      flush       <= 1'b0;
      wb_ecode    <= 6'h00;
      wb_esubcode <= 9'h000;
      wb_pc       <= 32'h0;
      wb_vaddr    <= 32'h0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wb_ex      <= take_ex;
      ertn_flush <= take_ertn;
      flush      <= (state_nxt == FLUSH);
      // Exception record is sticky until the next exception overwrites it.
      if (take_ex) begin
        wb_ecode    <= ecode_nxt;
        wb_esubcode <= 9'h000;
        wb_pc       <= ws_pc;
        wb_vaddr    <= vaddr_nxt;
      end
    end
  end

endmodule
